// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared types and defaults for the instruction fetch stage.
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Default datapath width of the fetch stage.
    localparam int FETCH_WIDTH = 32;

    // Default program counter after reset.
    localparam logic [FETCH_WIDTH-1:0] DEFAULT_RESET_PC = '0;

    // One buffered fetch result at the default width: the address it was read
    // from and the word that came back.
    typedef struct packed {
        logic [FETCH_WIDTH-1:0] pc;
        logic [FETCH_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_fifo
//  Purpose  : Small in-order buffer of fetch entries. Flush empties it in one
//             cycle; storage contents are never cleared, only the pointers.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output entry_t dout,
    output logic   full,
    output logic   empty
);

    localparam int                c_ptr_w   = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]  c_depth   = (c_ptr_w + 1)'(DEPTH);
    localparam logic [c_ptr_w:0]  c_cnt_one = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    entry_t             r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    // Status flags come only from the registered occupancy.
    assign full  = (r_count == c_depth);
    assign empty = (r_count == '0);

    // Never overrun a full buffer or underrun an empty one.
    assign w_push = push && !full;
    assign w_pop  = pop  && !empty;

    // Head entry, forced to zero while nothing is buffered.
    assign dout = empty ? '0 : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; flush drops everything at once.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents survive reset and flush.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch stage. Owns the PC, drives the combinational
//             imem read address, buffers {pc, instr} pairs and hands them to
//             the decoder over valid/ready. Redirect flushes and restarts.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH     = FETCH_WIDTH,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(DEFAULT_RESET_PC),
    parameter int               ADDR_STEP = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc
);

    localparam logic [WIDTH-1:0] c_step = WIDTH'(ADDR_STEP);

    // Entry layout follows the package type but tracks this instance's WIDTH.
    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
    } entry_t;

    logic [WIDTH-1:0] r_pc;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    entry_t           w_din;
    entry_t           w_dout;

    // A redirect cycle neither fetches nor offers anything: the PC and the
    // buffer contents are both about to be discarded.
    assign w_push      = !w_full && !redirect_valid;
    assign instr_valid = !w_empty && !redirect_valid;
    assign w_pop       = instr_valid && instr_ready;

    assign imem_addr = r_pc;
    assign w_din     = '{pc: r_pc, instr: imem_rdata};
    assign instr     = w_dout.instr;
    assign instr_pc  = w_dout.pc;

    // Program counter: reset > redirect > advance on a successful fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_push) begin
            r_pc <= r_pc + c_step;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit: directed scenarios push the
//             expected PC stream into a scoreboard, a monitor pops and compares
//             on every decoder handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb [$];
    logic [31:0] mon_pc;

    always #5 clk = ~clk;

    // Instruction memory image: a distinct word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0] ^ 16'h5A3C};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every leftover expectation at a flush point is a handshake that never came.
    task automatic sb_flush(input string name);
        check(name, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    // Start of a cycle (inputs change here) and mid-cycle sample point.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Monitor: every accepted instruction must be the next expected one.
    always @(negedge clk) begin
        if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_handshake: got pc %h, expected no transfer (t=%0t)", instr_pc, $time);
            end else begin
                mon_pc = sb.pop_front();
                check("hs_pc", instr_pc, mon_pc);
                check("hs_instr", instr, mem_word(mon_pc));
            end
        end
    end

    // Bound the whole run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        cyc();
        cyc();

        // Reset state.
        smp();
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);

        // Streaming with the decoder always ready.
        cyc();
        reset       = 1'b0;
        instr_ready = 1'b1;
        for (int i = 0; i < 7; i++) sb.push_back(32'(i * 4));
        for (int k = 0; k < 8; k++) begin
            if (k > 0) cyc();
            smp();
            check("stream_addr", imem_addr, 32'(k * 4));
            check("stream_valid", 32'(instr_valid), (k >= 1) ? 32'd1 : 32'd0);
        end

        // Backpressure from reset: four pushes, then the address holds.
        cyc();
        reset       = 1'b1;
        instr_ready = 1'b0;
        sb_flush("stream_drain");
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) cyc();
            smp();
            check("bp_addr", imem_addr, (k < 4) ? 32'(k * 4) : 32'h10);
            check("bp_valid", 32'(instr_valid), (k >= 1) ? 32'd1 : 32'd0);
            if (k >= 1) check("bp_head_pc", instr_pc, 32'h0);
        end
        cyc();
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) sb.push_back(32'(i * 4));
        for (int j = 0; j < 6; j++) begin
            if (j > 0) cyc();
            smp();
            check("bp_release_valid", 32'(instr_valid), 32'd1);
            check("bp_release_addr", imem_addr, (j < 2) ? 32'h10 : 32'(16 + 4 * (j - 1)));
        end

        // Redirect with three entries buffered and the decoder stalled.
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        instr_ready    = 1'b0;
        sb_flush("bp_drain");
        smp();
        check("redir_valid_low", 32'(instr_valid), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        sb.push_back(32'h40);
        sb.push_back(32'h44);
        sb.push_back(32'h48);
        smp();
        check("redir_addr", imem_addr, 32'h40);
        check("redir_bubble_valid", 32'(instr_valid), 32'd0);
        cyc();
        smp();
        check("redir_first_valid", 32'(instr_valid), 32'd1);
        check("redir_first_pc", instr_pc, 32'h40);
        cyc();
        cyc();

        // Redirect while the decoder is ready and the buffer is non-empty.
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        sb_flush("redir_drain");
        smp();
        check("redir_rdy_valid_low", 32'(instr_valid), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        sb.push_back(32'h100);
        sb.push_back(32'h104);
        smp();
        check("redir_rdy_addr", imem_addr, 32'h100);
        check("redir_rdy_bubble", 32'(instr_valid), 32'd0);
        cyc();
        smp();
        check("redir_rdy_first_pc", instr_pc, 32'h100);
        cyc();

        // Fill the buffer, then reset mid-run.
        for (int m = 0; m < 5; m++) begin
            cyc();
            if (m == 0) instr_ready = 1'b0;
            if (m >= 3) begin
                smp();
                check("full_addr_hold", imem_addr, 32'h118);
                check("full_head_pc", instr_pc, 32'h108);
            end
        end
        cyc();
        reset = 1'b1;
        sb_flush("redir_rdy_drain");
        cyc();
        reset       = 1'b0;
        instr_ready = 1'b1;
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        sb.push_back(32'h8);
        smp();
        check("midrst_valid", 32'(instr_valid), 32'd0);
        check("midrst_instr", instr, 32'h0);
        check("midrst_instr_pc", instr_pc, 32'h0);
        check("midrst_addr", imem_addr, 32'h0);
        cyc();
        smp();
        check("midrst_resume_pc", instr_pc, 32'h0);
        cyc();
        cyc();

        // Address wrap at the top of the space.
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        sb_flush("midrst_drain");
        smp();
        check("wrap_redir_valid", 32'(instr_valid), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        sb.push_back(32'hFFFF_FFFC);
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        smp();
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        cyc();
        smp();
        check("wrap_addr1", imem_addr, 32'h0);
        check("wrap_pc0", instr_pc, 32'hFFFF_FFFC);
        cyc();
        smp();
        check("wrap_addr2", imem_addr, 32'h4);
        check("wrap_pc1", instr_pc, 32'h0);
        cyc();
        cyc();
        instr_ready = 1'b0;
        sb_flush("wrap_drain");
        cyc();
        smp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of `imem`. It owns the program counter and drives `imem`'s combinational read address. It captures the returned instruction word together with its PC into a small in-order buffer and presents entries to the decoder over a valid/ready handshake. A redirect input (branch, jump or exception target) flushes the buffer and restarts fetch at a new PC.

## Interface
- `WIDTH`, 32: instruction and address width.
- `DEPTH`, 4: buffer entries; power of two, ≥ 2.
- `RESET_PC`, 0: PC loaded on reset.
- `ADDR_STEP`, 4: PC increment per fetched word (byte addressing).

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_addr`  out  WIDTH  address to `imem` `a`; equals the PC register.
- `imem_rdata`  in  WIDTH  `imem` `rd`; valid combinationally in the same cycle as `imem_addr`.
- `redirect_valid`  in  1  flush and restart request.
- `redirect_pc`  in  WIDTH  restart target; sampled when `redirect_valid`=1.
- `instr_valid`  out  1  head entry available to the decoder.
- `instr_ready`  in  1  decoder accepts the head entry.
- `instr`  out  WIDTH  head instruction word.
- `instr_pc`  out  WIDTH  PC of the head instruction.

## Operation
- State: `pc`; `count` (0..DEPTH); `wr_ptr`/`rd_ptr` (log2(DEPTH) bits, wrap modulo DEPTH); storage array of {pc, instr} entries.
- `full` = (`count`==DEPTH) and `empty` = (`count`==0). Both come from registered `count` only.
- `push` = !`full` && !`redirect_valid`. On push: write {`pc`, `imem_rdata`} at `wr_ptr`, then `pc` <= `pc` + ADDR_STEP.
- `pop` = `instr_valid` && `instr_ready`. On pop, `rd_ptr` advances.
- `instr_valid` = !`empty` && !`redirect_valid`.
- When `empty`, `instr` and `instr_pc` are driven 0. Otherwise they show the entry at `rd_ptr`.
- Priority per cycle is reset > redirect > push/pop.
- **Redirect:**
  - `count`, `wr_ptr` and `rd_ptr` all go to 0, and `pc` <= `redirect_pc`.
  - No push occurs, and no pop occurs, because `instr_valid` is forced low.
- **Push and pop in the same cycle:** `count` is unchanged and both pointers advance.
- **Full:** no push even if a pop occurs that cycle. The freed slot is refilled on the next cycle.
- **Empty with push:** no bypass; the entry becomes visible on the next cycle.
- **PC arithmetic:** WIDTH bits, wraps modulo 2^WIDTH with no fault. `redirect_pc` is used unaligned as given.
- **Reset:**
  - `pc`=RESET_PC, `count`=0, pointers 0.
  - Resulting outputs: `imem_addr`=RESET_PC, `instr_valid`=0, `instr`=0, `instr_pc`=0.
  - Storage contents are not cleared.

## Timing
- Address-to-output latency is 1 cycle: the word read at `imem_addr` in cycle N is offered on `instr` in cycle N+1 at the earliest.
- Throughput is 1 instruction/cycle while `instr_ready`=1 continuously.
- Redirect in cycle N:
  - `imem_addr`=`redirect_pc` in N+1.
  - The first instruction from the new stream is valid in N+2.
  - 2-cycle bubble.
- Backpressure: with `instr_ready`=0, exactly DEPTH pushes occur. After that, `imem_addr` holds until a pop.
- `instr_valid`, `instr`, and `instr_pc` depend only on registers and `redirect_valid`. There is no combinational path from `instr_ready` to any output.
- Reset asserted mid-operation takes effect at the next edge and discards buffered entries.

## Structure
- `fetch_pkg`: typedef `fetch_entry_t` struct {pc, instr} of WIDTH each, and localparam default `RESET_PC`.
- Sub-module `fetch_fifo`:
  - Parameterized by DEPTH and entry type.
  - Ports `push`, `pop`, `flush`, `din`, `dout`, `full`, `empty`, with the same synchronous reset.
  - `fetch_unit` holds the PC logic and instantiates `fetch_fifo` plus handshake glue.

## Test plan
- **Streaming:** `reset` released, `instr_ready`=1, `imem` loaded from memfile.dat.
  - `imem_addr` runs 0,4,8,…
  - `instr_valid` rises 1 cycle after the first fetch.
  - `instr_pc` runs 0,4,8,… one per cycle, and `instr` matches memfile words 0,1,2.
- **Backpressure:** `instr_ready`=0 from reset.
  - After 4 pushes, `count`=4, `imem_addr` holds at 0x10, and `instr_pc` holds at 0.
  - Then `instr_ready`=1: `instr_pc` gives 0,4,8,0xC,0x10 in order, with no gaps after the first refill.
- **Redirect with entries buffered:** 3 entries buffered, `redirect_valid`=1, `redirect_pc`=0x40.
  - `instr_valid`=0 during that cycle.
  - Next cycle: `imem_addr`=0x40, `instr_valid`=0.
  - Cycle after: `instr_pc`=0x40, and none of the old entries appear.
- **Redirect with ready:** `redirect_valid`=1 and `instr_ready`=1 while non-empty.
  - No pop is recorded and `instr_valid`=0 in that cycle.
  - The flush completes as in the previous scenario.
- **Reset mid-run:** `reset` asserted for 1 cycle with a full buffer.
  - Next cycle: `instr_valid`=0, `instr`=0, `imem_addr`=RESET_PC.
  - Fetch resumes from 0.
- **Wrap:** redirect to 0xFFFFFFFC with `instr_ready`=1.
  - `imem_addr` runs 0xFFFFFFFC, then 0x00000000.
  - `instr_pc` follows the same sequence.
